// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and BRAM-port signals around the instruction-memory arbiter.
// The master modport is the arbiter's view; slave is the surrounding CPU/loader/BRAM side.
interface imem_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              go;

    logic [31:0]       f_addr;
    logic [31:0]       f_instr;
    logic              f_stall;
    logic              cpu_hold;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;
    logic [31:0]       ld_rdata;
    logic [15:0]       ld_cnt;

    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport master (
        input  go, f_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_dout,
        output f_instr, f_stall, cpu_hold, ld_ack, ld_rdata, ld_cnt,
               mem_addr, mem_we, mem_din
    );

    modport slave (
        output go, f_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_dout,
        input  f_instr, f_stall, cpu_hold, ld_ack, ld_rdata, ld_cnt,
               mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single instruction-memory BRAM port between CPU fetch and the program
// loader; holds the CPU in BOOT while the loader fills memory, then interleaves.
module imem_arbiter #(
    parameter int          ADDR_W = 11,
    parameter logic [31:0] BASE   = 32'h3000
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.master bus
);
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_reg, state_next;
    logic        go_pend_reg, go_pend_next;
    logic        fair_reg;
    logic        ack_reg, ack_we_reg;
    logic        fetch_ok_reg;
    logic [31:0] rdata_reg;
    logic [15:0] cnt_reg;

    logic [31:0] loc;
    logic        aligned, in_range;
    logic        grant_ld, grant_fetch;
    logic        ack, write_ack;
    logic [31:0] rdata;

    // rst is active-low, so every grant and the ack are qualified by rst being high.
    always_comb begin
        loc         = bus.f_addr - BASE;
        aligned     = (loc[1:0] == 2'b00);
        in_range    = ((loc >> (ADDR_W + 2)) == 32'd0);
        grant_ld    = rst & bus.ld_req & ((state_reg == BOOT) | ~fair_reg);
        grant_fetch = rst & (state_reg == RUN) & ~grant_ld;
        ack         = rst & ack_reg;
        write_ack   = ack & ack_we_reg;
        rdata       = (ack & ~ack_we_reg) ? bus.mem_dout : rdata_reg;
    end

    // A go seen while the loader owns the port is parked until a free cycle.
    always_comb begin
        state_next   = state_reg;
        go_pend_next = go_pend_reg;
        if (state_reg == BOOT) begin
            if ((bus.go | go_pend_reg) & ~grant_ld) begin
                state_next   = RUN;
                go_pend_next = 1'b0;
            end else if (bus.go) begin
                go_pend_next = 1'b1;
            end
        end
    end

    assign bus.mem_addr = grant_ld ? bus.ld_addr : loc[ADDR_W+1:2];
    assign bus.mem_din  = bus.ld_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_we
            assign bus.mem_we[gi] = grant_ld & bus.ld_we;
        end
    endgenerate

    assign bus.f_stall  = ~grant_fetch;
    assign bus.cpu_hold = ~rst | (state_reg == BOOT);
    assign bus.f_instr  = (rst & fetch_ok_reg) ? bus.mem_dout : 32'd0;
    assign bus.ld_ack   = ack;
    assign bus.ld_rdata = rdata;
    assign bus.ld_cnt   = cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= BOOT;
            go_pend_reg  <= 1'b0;
            fair_reg     <= 1'b0;
            ack_reg      <= 1'b0;
            ack_we_reg   <= 1'b0;
            fetch_ok_reg <= 1'b0;
            rdata_reg    <= 32'd0;
            cnt_reg      <= 16'd0;
        end else begin
            state_reg    <= state_next;
            go_pend_reg  <= go_pend_next;
            fair_reg     <= grant_ld;
            ack_reg      <= grant_ld;
            ack_we_reg   <= bus.ld_we;
            fetch_ok_reg <= grant_fetch & aligned & in_range;
            rdata_reg    <= rdata;
            if (write_ack && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the arbiter rules and the memory contents.
module tb_imem_arbiter;
    localparam int          ADDR_W = 11;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    imem_arbiter #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] seed_word(input int i);
        return 32'hA500_0000 ^ 32'(i * 32'h0001_0003);
    endfunction

    // Environment BRAM: registered read, read-first, loaded with a known pattern.
    logic [31:0] bram [DEPTH];
    bit          bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= seed_word(i);
            bram_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) bram[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
        end
        bus.mem_dout <= bram[bus.mem_addr];
    end

    // Reference model state
    logic [31:0] mm [DEPTH];
    bit          m_run, m_pend, m_last_ld, m_ack_due, m_ack_we, m_fetch_ok;
    logic [31:0] m_ack_word, m_fetch_word, m_rdata;
    int unsigned m_cnt;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ld_owns();
        return rst && bus.ld_req && (!m_run || !m_last_ld);
    endfunction

    function automatic bit fetch_owns();
        return rst && m_run && !ld_owns();
    endfunction

    task automatic model_check();
        logic [31:0] off;
        bit ld, fe;
        off = bus.f_addr - BASE;
        ld  = ld_owns();
        fe  = fetch_owns();
        check("f_stall", 32'(bus.f_stall), 32'(!fe));
        check("cpu_hold", 32'(bus.cpu_hold), 32'(!rst || !m_run));
        check("mem_we", 32'(bus.mem_we), (ld && bus.ld_we) ? 32'hF : 32'h0);
        if (ld) begin
            check("mem_addr_ld", 32'(bus.mem_addr), 32'(bus.ld_addr));
            if (bus.ld_we) check("mem_din", bus.mem_din, bus.ld_wdata);
        end else if (fe) begin
            check("mem_addr_fetch", 32'(bus.mem_addr), (off / 4) % DEPTH);
        end
        check("ld_ack", 32'(bus.ld_ack), 32'(rst && m_ack_due));
        check("ld_rdata", bus.ld_rdata, (rst && m_ack_due && !m_ack_we) ? m_ack_word : m_rdata);
        check("ld_cnt", 32'(bus.ld_cnt), m_cnt);
        check("f_instr", bus.f_instr, (rst && m_fetch_ok) ? m_fetch_word : 32'h0);
    endtask

    task automatic model_update();
        logic [31:0] off;
        bit ld, fe;
        off = bus.f_addr - BASE;
        ld  = ld_owns();
        fe  = fetch_owns();
        if (!rst) begin
            m_run = 0; m_pend = 0; m_last_ld = 0; m_ack_due = 0; m_fetch_ok = 0;
            m_cnt = 0; m_rdata = 32'h0;
            return;
        end
        if (m_ack_due) begin
            if (m_ack_we) begin
                if (m_cnt < 32'hFFFF) m_cnt++;
            end else begin
                m_rdata = m_ack_word;
            end
        end
        m_fetch_ok = fe && (off % 4 == 0) && (off < 4 * DEPTH);
        if (fe) m_fetch_word = mm[(off / 4) % DEPTH];
        m_ack_due = ld;
        m_last_ld = ld;
        if (ld) begin
            m_ack_we   = bus.ld_we;
            m_ack_word = mm[bus.ld_addr];
            if (bus.ld_we) mm[bus.ld_addr] = bus.ld_wdata;
        end
        if (!m_run) begin
            if ((bus.go || m_pend) && !ld) begin
                m_run  = 1;
                m_pend = 0;
            end else if (bus.go) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        half();
        tick();
    endtask

    task automatic set_idle();
        bus.go       = 1'b0;
        bus.ld_req   = 1'b0;
        bus.ld_we    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_wdata = 32'h0;
    endtask

    task automatic drive_ld(input bit req, input bit we, input int addr, input logic [31:0] data);
        bus.ld_req   = req;
        bus.ld_we    = we;
        bus.ld_addr  = ADDR_W'(addr);
        bus.ld_wdata = data;
    endtask

    int  ack_n;
    bit  ack_now;
    int  pick;

    initial begin
        rst = 1'b0;
        set_idle();
        bus.f_addr = BASE;
        for (int i = 0; i < DEPTH; i++) mm[i] = seed_word(i);
        m_rdata = 32'h0; m_ack_word = 32'h0; m_fetch_word = 32'h0;
        @(posedge clk);
        model_update();
        #1;

        // Reset held, then idle in BOOT
        step();
        step();
        rst = 1'b1;
        half();
        check("rst_f_stall", 32'(bus.f_stall), 32'd1);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_ld_ack", 32'(bus.ld_ack), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_ld_cnt", 32'(bus.ld_cnt), 32'd0);
        check("rst_f_instr", bus.f_instr, 32'd0);
        tick();

        // BOOT back-to-back writes
        drive_ld(1, 1, 0, 32'hDEADBEEF);
        half(); check("w0_we", 32'(bus.mem_we), 32'hF); tick();
        drive_ld(1, 1, 1, 32'h12345678);
        half(); check("w0_ack", 32'(bus.ld_ack), 32'd1); check("w1_we", 32'(bus.mem_we), 32'hF); tick();
        drive_ld(1, 1, 2, 32'h0000000C);
        half(); check("w1_ack", 32'(bus.ld_ack), 32'd1); check("w2_we", 32'(bus.mem_we), 32'hF); tick();
        set_idle();
        half(); check("w2_ack", 32'(bus.ld_ack), 32'd1); tick();

        // Read-back
        drive_ld(1, 0, 1, 32'h0);
        half(); check("cnt3", 32'(bus.ld_cnt), 32'd3); check("rd_we", 32'(bus.mem_we), 32'd0); tick();
        set_idle();
        half(); check("rd_ack", 32'(bus.ld_ack), 32'd1); check("rd_data", bus.ld_rdata, 32'h12345678); tick();

        // Release and fetch
        bus.go = 1'b1;
        half(); check("go_hold", 32'(bus.cpu_hold), 32'd1); tick();
        bus.go = 1'b0;
        bus.f_addr = 32'h3004;
        half();
        check("run_hold", 32'(bus.cpu_hold), 32'd0);
        check("fetch_stall", 32'(bus.f_stall), 32'd0);
        check("fetch_addr", 32'(bus.mem_addr), 32'd1);
        tick();
        bus.f_addr = 32'h3006;
        half(); check("fetch_instr", bus.f_instr, 32'h12345678); tick();
        bus.f_addr = 32'h3000;
        half(); check("misalign_instr", bus.f_instr, 32'h0); tick();

        // RUN contention: four reads with ld_req held
        ack_n = 0;
        for (int k = 0; k < 7; k++) begin
            drive_ld(1, 0, (k + 1) / 2, 32'h0);
            half();
            check("cont_stall", 32'(bus.f_stall), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (bus.ld_ack) ack_n++;
            tick();
        end
        set_idle();
        half(); if (bus.ld_ack) ack_n++; tick();
        check("cont_acks", 32'(ack_n), 32'd4);

        // go coinciding with a write grant
        rst = 1'b0; step(); rst = 1'b1;
        drive_ld(1, 1, 5, 32'hCAFEF00D);
        bus.go = 1'b1;
        half(); check("gp_hold0", 32'(bus.cpu_hold), 32'd1); tick();
        set_idle();
        half(); check("gp_ack", 32'(bus.ld_ack), 32'd1); check("gp_hold1", 32'(bus.cpu_hold), 32'd1); tick();
        half(); check("gp_run", 32'(bus.cpu_hold), 32'd0); check("gp_stall", 32'(bus.f_stall), 32'd0); tick();

        // Reset on the ack cycle
        rst = 1'b0; step(); rst = 1'b1;
        drive_ld(1, 1, 6, 32'h0BADCAFE);
        step();
        set_idle();
        rst = 1'b0;
        half(); check("rs_noack", 32'(bus.ld_ack), 32'd0); tick();
        rst = 1'b1;
        half();
        check("rs_cnt", 32'(bus.ld_cnt), 32'd0);
        check("rs_hold", 32'(bus.cpu_hold), 32'd1);
        check("rs_ack", 32'(bus.ld_ack), 32'd0);
        tick();
        check("rs_mem", bram[6], 32'h0BADCAFE);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ack_now = bus.ld_ack;
            if (!bus.ld_req || ack_now) begin
                if ($urandom_range(0, 9) < 6)
                    drive_ld(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 32'($urandom));
                else
                    drive_ld(0, 0, 0, 32'h0);
            end
            rst    = ($urandom_range(0, 99) != 0);
            bus.go = ($urandom_range(0, 29) == 0);
            pick   = $urandom_range(0, 9);
            if (pick < 6)       bus.f_addr = BASE + 32'(4 * $urandom_range(0, 15));
            else if (pick == 6) bus.f_addr = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (pick == 7) bus.f_addr = BASE - 32'(4 * $urandom_range(1, 4));
            else if (pick == 8) bus.f_addr = BASE + 32'(4 * (DEPTH + $urandom_range(0, 3)));
            else                bus.f_addr = BASE + 32'(4 * (DEPTH - 1));
            step();
        end
        set_idle();
        rst = 1'b1;
        step();
        step();

        for (int i = 0; i < 16; i++) check("final_mem", bram[i], mm[i]);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule
